// File: rtl/alu_execute_unit.sv
// Execute stage behind the ALU operand-select: single-cycle arithmetic/logic ops,
// one-bit-per-cycle iterative shifts, and a registered result behind a valid/ready handshake.
module alu_execute_unit #(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] DATA0,
  input  logic [N-1:0] DATA1,
  input  logic         ALU_EN,
  input  logic [6:0]   OPCODE,
  input  logic [2:0]   FUNCT3,
  input  logic         FUNCT1,
  output logic         IN_READY,
  output logic [N-1:0] RESULT,
  output logic         RESULT_VALID,
  input  logic         RESULT_READY
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [N-1:0]     shift_reg;
  logic [SHW-1:0]   shift_cnt;
  logic             shift_left;
  logic             shift_arith;

  logic             is_alu_op;
  logic             is_shift;
  logic             is_sub;
  logic [SHW-1:0]   shamt;
  logic [N-1:0]     alu_out;
  logic [N-1:0]     shift_next;
  logic             accept;

  assign IN_READY = (state == IDLE) && !RESET;
  assign accept   = ALU_EN && IN_READY;
  assign shamt    = DATA1[SHW-1:0];

  // Non-ALU opcodes (loads, stores, LUI, AUIPC) only ever need an address add.
  assign is_alu_op = (OPCODE == OP_IMM) || (OPCODE == OP_REG);
  assign is_shift  = is_alu_op && ((FUNCT3 == 3'b001) || (FUNCT3 == 3'b101));
  assign is_sub    = (OPCODE == OP_REG) && FUNCT1 && (FUNCT3 == 3'b000);

  always_comb begin
    alu_out = DATA0 + DATA1;
    if (is_alu_op) begin
      case (FUNCT3)
        3'b000:  alu_out = is_sub ? (DATA0 + ~DATA1 + {{(N-1){1'b0}}, 1'b1}) : (DATA0 + DATA1);
        3'b010:  alu_out = {{(N-1){1'b0}}, ($signed(DATA0) < $signed(DATA1))};
        3'b011:  alu_out = {{(N-1){1'b0}}, (DATA0 < DATA1)};
        3'b100:  alu_out = DATA0 ^ DATA1;
        3'b110:  alu_out = DATA0 | DATA1;
        3'b111:  alu_out = DATA0 & DATA1;
        default: alu_out = DATA0;
      endcase
    end
  end

  always_comb begin
    shift_next = {1'b0, shift_reg[N-1:1]};
    if (shift_left)
      shift_next = {shift_reg[N-2:0], 1'b0};
    else if (shift_arith)
      shift_next = {shift_reg[N-1], shift_reg[N-1:1]};
  end

  // A zero shift amount falls through the single-cycle path, where alu_out passes DATA0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      shift_cnt    <= '0;
      shift_reg    <= '0;
      shift_left   <= 1'b0;
      shift_arith  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              shift_reg   <= DATA0;
              shift_cnt   <= shamt;
              shift_left  <= (FUNCT3 == 3'b001);
              shift_arith <= (FUNCT3 == 3'b101) && FUNCT1;
              state       <= SHIFT;
            end else begin
              RESULT       <= alu_out;
              RESULT_VALID <= 1'b1;
              state        <= DONE;
            end
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          shift_cnt <= shift_cnt - {{(SHW-1){1'b0}}, 1'b1};
          if (shift_cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
            RESULT       <= shift_next;
            RESULT_VALID <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (RESULT_READY) begin
            RESULT_VALID <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed-vector bench for alu_execute_unit: hand-computed results, latencies,
// backpressure and mid-shift reset behaviour.
module tb_alu_execute_unit;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  logic        clk;
  logic        reset;
  logic [31:0] data0;
  logic [31:0] data1;
  logic        alu_en;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct1;
  logic        in_ready;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;

  int checkCount;
  int passCount;
  int latency;
  logic busySeenReady;

  alu_execute_unit #(.N(32)) dut (
    .CLK(clk),
    .RESET(reset),
    .DATA0(data0),
    .DATA1(data1),
    .ALU_EN(alu_en),
    .OPCODE(opcode),
    .FUNCT3(funct3),
    .FUNCT1(funct1),
    .IN_READY(in_ready),
    .RESULT(result),
    .RESULT_VALID(result_valid),
    .RESULT_READY(result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, lets it be accepted, scrambles the inputs, then
  // waits (bounded) for RESULT_VALID while recording the latency in edges.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f1,
                               input logic [31:0] d0, input logic [31:0] d1);
    opcode = op;
    funct3 = f3;
    funct1 = f1;
    data0  = d0;
    data1  = d1;
    alu_en = 1'b1;
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    tick();
    alu_en = 1'b0;
    data0  = 32'hDEADBEEF;
    data1  = 32'h0000001F;
    funct3 = 3'b100;
    opcode = OP_REG;
    latency = 1;
    busySeenReady = 1'b0;
    while (!result_valid && latency < 100) begin
      if (in_ready) busySeenReady = 1'b1;
      tick();
      latency++;
    end
  endtask

  task automatic releaseResult();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checkOutput("valid_after_handoff", {31'd0, result_valid}, 32'd0);
    checkOutput("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] expResult, input int expLatency);
    applyStimulus(op, f3, f1, d0, d1);
    checkOutput({tag, "_result"}, result, expResult);
    checkOutput({tag, "_latency"}, latency, expLatency);
    checkOutput({tag, "_busy"}, {31'd0, busySeenReady}, 32'd0);
    releaseResult();
  endtask

  initial begin
    checkCount   = 0;
    passCount    = 0;
    reset        = 1'b1;
    alu_en       = 1'b0;
    data0        = 32'd0;
    data1        = 32'd0;
    opcode       = 7'd0;
    funct3       = 3'd0;
    funct1       = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    runOp("add_wrap", OP_REG,  3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1);
    runOp("sub",      OP_REG,  3'b000, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
    runOp("addi_f1",  OP_IMM,  3'b000, 1'b1, 32'd5, 32'd7, 32'h0000000C, 1);
    runOp("load_add", OP_LOAD, 3'b010, 1'b1, 32'd5, 32'd7, 32'h0000000C, 1);
    runOp("slt",      OP_REG,  3'b010, 1'b0, 32'h80000000, 32'h00000001, 32'h00000001, 1);
    runOp("sltu",     OP_REG,  3'b011, 1'b0, 32'h80000000, 32'h00000001, 32'h00000000, 1);
    runOp("xor",      OP_REG,  3'b100, 1'b0, 32'hF0F0A5A5, 32'h0FF05A5A, 32'hFF00FFFF, 1);
    runOp("or",       OP_IMM,  3'b110, 1'b0, 32'h12340000, 32'h00005678, 32'h12345678, 1);
    runOp("and",      OP_REG,  3'b111, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1);
    runOp("sra4",     OP_REG,  3'b101, 1'b1, 32'hF0000000, 32'h00000024, 32'hFF000000, 5);
    runOp("srl4",     OP_REG,  3'b101, 1'b0, 32'hF0000000, 32'h00000024, 32'h0F000000, 5);
    runOp("srai4",    OP_IMM,  3'b101, 1'b1, 32'hF0000000, 32'h00000004, 32'hFF000000, 5);
    runOp("sll31",    OP_IMM,  3'b001, 1'b0, 32'h00000001, 32'h0000001F, 32'h80000000, 32);
    runOp("sll0",     OP_REG,  3'b001, 1'b0, 32'h12345678, 32'h00000020, 32'h12345678, 1);

    // Backpressure: result must stay put and a new request must wait.
    applyStimulus(OP_REG, 3'b000, 1'b0, 32'd100, 32'd23);
    checkOutput("bp_result", result, 32'd123);
    opcode = OP_REG;
    funct3 = 3'b000;
    funct1 = 1'b0;
    data0  = 32'd40;
    data1  = 32'd2;
    alu_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_hold_result", result, 32'd123);
      checkOutput("bp_hold_valid", {31'd0, result_valid}, 32'd1);
      checkOutput("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    releaseResult();
    checkOutput("bp_result_retained", result, 32'd123);
    tick();
    alu_en = 1'b0;
    checkOutput("bp_new_valid", {31'd0, result_valid}, 32'd1);
    checkOutput("bp_new_result", result, 32'd42);
    releaseResult();

    // Reset in the middle of a 20-bit shift discards the operation.
    opcode = OP_REG;
    funct3 = 3'b101;
    funct1 = 1'b0;
    data0  = 32'hFFFFFFFF;
    data1  = 32'd20;
    alu_en = 1'b1;
    tick();
    alu_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("mid_shift_busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_result", result, 32'd0);
    checkOutput("rst_mid_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("rst_mid_in_ready_after", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("rst_mid_no_result", {31'd0, result_valid}, 32'd0);
    runOp("add_after_reset", OP_REG, 3'b000, 1'b0, 32'h00001000, 32'h00000234, 32'h00001234, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
